// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core: one-hot stage enables, CC register, status.
// Optional retired-instruction counter port instr_count is built when SEQ_PERF_CNT_EN is defined.
module seq_stage_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        imem_error,
  input  logic        mem_ready,
  input  logic        dmem_error,
  input  logic [2:0]  cndflags_in,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        memory_en,
  output logic        writeback_en,
  output logic        pc_update_en,
  output logic        mem_req,
  output logic [2:0]  cc,
  output logic        cc_we,
  output logic [1:0]  stat,
  output logic        busy
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] instr_count
`endif
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_PCUPD     = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  logic [2:0] state, state_nxt;
  logic [1:0] stat_nxt;
  logic [3:0] icode_q;
  logic       mem_op;

  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
  always_comb begin
    mem_op = 1'b0;
    case (icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: mem_op = 1'b1;
      default:                            mem_op = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    stat_nxt  = stat;
    case (state)
      S_IDLE:      if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_error) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end else if (icode > 4'hB) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_INS;
        end else if (icode == 4'h0) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_HLT;
        end else begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE:    state_nxt = S_EXECUTE;
      S_EXECUTE:   state_nxt = S_MEMORY;
      S_MEMORY: begin
        if (!mem_op) begin
          state_nxt = S_WRITEBACK;
        end else if (mem_ready) begin
          if (dmem_error) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_ADR;
          end else begin
            state_nxt = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: state_nxt = S_PCUPD;
      S_PCUPD:     state_nxt = S_FETCH;
      S_HALT:      state_nxt = S_HALT;
      default:     state_nxt = S_IDLE;
    endcase
  end

  assign fetch_en     = (state == S_FETCH);
  assign decode_en    = (state == S_DECODE);
  assign execute_en   = (state == S_EXECUTE);
  assign memory_en    = (state == S_MEMORY);
  assign writeback_en = (state == S_WRITEBACK);
  assign pc_update_en = (state == S_PCUPD);
  assign mem_req      = (state == S_MEMORY) && mem_op;
  assign cc_we        = (state == S_EXECUTE) && (icode_q == 4'h6);
  assign busy         = (state != S_IDLE) && (state != S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      stat    <= STAT_AOK;
      icode_q <= '0;
      cc      <= 3'b001;
    end else begin
      state <= state_nxt;
      stat  <= stat_nxt;
      if (state == S_FETCH) icode_q <= icode;
      if (cc_we)            cc      <= cndflags_in;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                instr_count <= '0;
    else if (state == S_PCUPD) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule
